ll_detect_ctrl: RTL
===================

// Module: ll_detect_ctrl
// PURPOSE
//  Consumer end of the line-length windowed-sum stream: accepts one signed window sum per
//  valid/ready beat and decides seizure onset/offset. Threshold hysteresis, N-consecutive-sample
//  trigger, post-event holdoff. Sits between the window summation stage and the system controller.
// PARAMETERS
//  DATA_W    64   width of incoming window sum and thresholds (signed)
//  CNT_W     8    width of trigger-count and run counter
//  HOLD_W    16   width of holdoff sample counter
//  EVT_W     16   width of event counter (LL_EVENT_CNT_EN only)
// PORTS
//  clk          in   1        clock
//  rst          in   1        reset, synchronous, active-high
//  en           in   1        enable, active-low; high = freeze all state
//  sum_in       in   DATA_W   signed window sum
//  sum_valid    in   1        sum_in valid
//  sum_ready    out  1        block accepts beat; = ~en & ~rst (combinational)
//  thresh_hi    in   DATA_W   signed onset threshold
//  thresh_lo    in   DATA_W   signed offset threshold
//  trig_cnt     in   CNT_W    consecutive over-threshold samples required (0 treated as 1)
//  holdoff      in   HOLD_W   accepted samples ignored after offset
//  detect       out  1        registered; high in DETECT state
//  detect_pulse out  1        registered; 1-cycle pulse on entry to DETECT
//  state_o      out  2        current state encoding
//  event_cnt    out  EVT_W    detections since reset (LL_EVENT_CNT_EN only)
// BEHAVIOUR
//  - Reset: state IDLE, run_cnt=0, hold_cnt=0, detect=0, detect_pulse=0, event_cnt=0.
//    Reset mid-operation aborts any run/holdoff; first accepted beat after reset starts from IDLE.
//  - Beat accepted on rising clk when sum_valid & sum_ready. No beat => state/counters hold,
//    detect_pulse deasserts. en high => sum_ready=0, everything holds (pulse cleared).
//  - All comparisons signed, full DATA_W: over = sum_in > thresh_hi; under = sum_in < thresh_lo.
//  - States (state_o): IDLE=0, ARMED=1, DETECT=2, HOLDOFF=3. Per accepted beat:
//    IDLE:    over -> run_cnt=1; to DETECT if eff_trig==1 else ARMED. else stay, run_cnt=0.
//    ARMED:   over -> run_cnt+1; if run_cnt+1 >= eff_trig -> DETECT. not over -> IDLE, run_cnt=0.
//    DETECT:  under -> HOLDOFF, hold_cnt=holdoff, run_cnt=0; if holdoff==0 go IDLE directly.
//             otherwise stay (values between thresholds keep DETECT).
//    HOLDOFF: thresholds ignored; hold_cnt-1; when hold_cnt reaches 1 -> IDLE, hold_cnt=0.
//  - run_cnt saturates at all-ones; eff_trig = (trig_cnt==0) ? 1 : trig_cnt.
//  - Latency: detect/detect_pulse/state_o reflect a beat the cycle after its accepting edge.
//  - thresh_lo > thresh_hi is legal; rules above apply literally (DETECT may exit next beat).
//  - Threshold/trig/holdoff inputs sampled on each accepted beat; no shadowing.
// CONFIGURATION
//  LL_EVENT_CNT_EN defined: event_cnt port present; +1 on each entry to DETECT, saturates at
//  all-ones, cleared only by rst. Undefined: port and counter absent; all else identical.
// STRUCTURE
//  Shared package ll_pkg: ll_state_t enum (IDLE/ARMED/DETECT/HOLDOFF, 2-bit),
//  default LL_DATA_W=64 consistent with summation stage output width.
//  One sub-module: ll_holdoff_timer (load/decrement-on-beat/expire, HOLD_W); FSM and
//  comparators stay in ll_detect_ctrl.
// TESTING
//  1. rst high 2 cycles, sum_valid=1 -> sum_ready=0, detect=0, state_o=0, event_cnt=0.
//  2. hi=100, lo=50, trig=3; beats 120,130,140 -> state 1,1,2; detect_pulse 1 cycle after 3rd beat.
//  3. Same cfg; beats 120,130,90,120 -> ARMED,ARMED,IDLE,ARMED; detect never high.
//  4. In DETECT, beats 70,40 then holdoff=2 with beats 500,500 -> stays 2, to 3, then IDLE
//     after 2nd 500 beat; no retrigger during holdoff.
//  5. Mid-ARMED hold en=1 for 5 cycles with sum_valid=1 -> sum_ready=0, state/run_cnt frozen;
//     rst during DETECT -> IDLE, detect=0 next cycle.
//  6. trig=0, hi=-10 signed, sum=-5 -> DETECT on first beat; sum=-20 vs lo=-15 exits (signed compare);
//     with LL_EVENT_CNT_EN two detections -> event_cnt=2.

Source files
------------

// File: rtl/ll_pkg.sv
// Shared types and default widths for the line-length detection path.
// Default LL_DATA_W matches the summation stage output width.
package ll_pkg;

  localparam int LL_DATA_W = 64;
  localparam int LL_CNT_W  = 8;
  localparam int LL_HOLD_W = 16;
  localparam int LL_EVT_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    DETECT  = 2'd2,
    HOLDOFF = 2'd3
  } ll_state_t;

endpackage

// File: rtl/ll_holdoff_timer.sv
// Post-event holdoff counter: loads the holdoff length, counts down once per
// accepted beat, and flags the final beat so the controller can return to IDLE.
module ll_holdoff_timer
  import ll_pkg::*;
#(
  parameter int HOLD_W = LL_HOLD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [HOLD_W-1:0] i_load_val,
  input  logic              i_dec,
  output logic              o_last
);

  logic [HOLD_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      // The beat that sees a count of 1 is the last ignored one; park at 0.
      if (r_count <= HOLD_W'(1)) begin
        r_count <= '0;
      end else begin
        r_count <= r_count - HOLD_W'(1);
      end
    end
  end

  assign o_last = (r_count <= HOLD_W'(1));

endmodule

// File: rtl/ll_detect_ctrl.sv
// Seizure onset/offset decision on the windowed line-length sum stream.
// Optional event counter enabled by defining LL_EVENT_CNT_EN.
module ll_detect_ctrl
  import ll_pkg::*;
#(
  parameter int DATA_W = LL_DATA_W,
  parameter int CNT_W  = LL_CNT_W,
  parameter int HOLD_W = LL_HOLD_W
`ifdef LL_EVENT_CNT_EN
  ,
  parameter int EVT_W  = LL_EVT_W
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sum_in,
  input  logic                     sum_valid,
  output logic                     sum_ready,
  input  logic signed [DATA_W-1:0] thresh_hi,
  input  logic signed [DATA_W-1:0] thresh_lo,
  input  logic        [CNT_W-1:0]  trig_cnt,
  input  logic        [HOLD_W-1:0] holdoff,
  output logic                     detect,
  output logic                     detect_pulse,
  output logic        [1:0]        state_o
`ifdef LL_EVENT_CNT_EN
  ,
  output logic        [EVT_W-1:0]  event_cnt
`endif
);

  ll_state_t        r_state;
  ll_state_t        w_state_next;
  logic [CNT_W-1:0] r_run_cnt;
  logic [CNT_W-1:0] w_run_cnt_next;
  logic [CNT_W-1:0] w_run_inc;
  logic [CNT_W-1:0] w_eff_trig;
  logic             r_detect;
  logic             r_pulse;
  logic             w_detect_next;
  logic             w_pulse_next;
  logic             w_accept;
  logic             w_over;
  logic             w_under;
  logic             w_hold_load;
  logic             w_hold_dec;
  logic             w_hold_last;

  // en is active-low: high freezes the block and withholds ready.
  assign sum_ready  = ~en & ~rst;
  assign w_accept   = sum_valid & sum_ready;
  assign w_over     = (sum_in > thresh_hi);
  assign w_under    = (sum_in < thresh_lo);
  assign w_eff_trig = (trig_cnt == '0) ? CNT_W'(1) : trig_cnt;
  assign w_run_inc  = (&r_run_cnt) ? r_run_cnt : r_run_cnt + CNT_W'(1);

  ll_holdoff_timer #(
    .HOLD_W(HOLD_W)
  ) u_holdoff_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept & w_hold_load),
    .i_load_val(holdoff),
    .i_dec     (w_accept & w_hold_dec),
    .o_last    (w_hold_last)
  );

  // State register, including the registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_run_cnt <= '0;
      r_detect  <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_pulse <= w_pulse_next;
      if (w_accept) begin
        r_state   <= w_state_next;
        r_run_cnt <= w_run_cnt_next;
        r_detect  <= w_detect_next;
      end
    end
  end

  // Next-state logic, evaluated for the beat currently presented.
  always_comb begin
    w_state_next   = r_state;
    w_run_cnt_next = r_run_cnt;
    w_hold_load    = 1'b0;
    w_hold_dec     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_over) begin
          w_run_cnt_next = CNT_W'(1);
          w_state_next   = (w_eff_trig == CNT_W'(1)) ? DETECT : ARMED;
        end else begin
          w_run_cnt_next = '0;
        end
      end
      ARMED: begin
        if (w_over) begin
          w_run_cnt_next = w_run_inc;
          if (w_run_inc >= w_eff_trig) begin
            w_state_next = DETECT;
          end
        end else begin
          w_run_cnt_next = '0;
          w_state_next   = IDLE;
        end
      end
      DETECT: begin
        // Values between the thresholds keep the detection asserted.
        if (w_under) begin
          w_run_cnt_next = '0;
          w_hold_load    = 1'b1;
          w_state_next   = (holdoff == '0) ? IDLE : HOLDOFF;
        end
      end
      HOLDOFF: begin
        w_hold_dec = 1'b1;
        if (w_hold_last) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_run_cnt_next = '0;
      end
    endcase
  end

  // Output logic: next values of the registered status outputs.
  always_comb begin
    w_detect_next = (w_state_next == DETECT);
    w_pulse_next  = w_accept & (w_state_next == DETECT) & (r_state != DETECT);
  end

  assign detect       = r_detect;
  assign detect_pulse = r_pulse;
  assign state_o      = r_state;

`ifdef LL_EVENT_CNT_EN
  logic [EVT_W-1:0] r_event_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_event_cnt <= '0;
    end else if (w_pulse_next && !(&r_event_cnt)) begin
      r_event_cnt <= r_event_cnt + EVT_W'(1);
    end
  end

  assign event_cnt = r_event_cnt;
`endif

endmodule
